// File: rtl/led_frame_sched.sv
// LED frame scheduler: refresh timer, host/test-pattern arbitration and a
// single-launch-in-flight PHY handshake with sticky timeout/overrun reporting.
module led_frame_sched #(
    parameter int DATA_W      = 128,
    parameter int REFRESH_CYC = 25000,
    parameter int PHY_TO      = 4096,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [DATA_W-1:0] host_data,
    input  logic              pat_en,
    input  logic [DATA_W-1:0] pat_data,
    output logic              phy_enable,
    output logic [DATA_W-1:0] phy_data,
    input  logic              phy_done,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              timeout_err,
    output logic              overrun_err,
    input  logic              err_clr
);
    localparam int TMR_W = $clog2(REFRESH_CYC);
    localparam int WT_W  = $clog2(PHY_TO);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t            state, state_nxt;
    logic [TMR_W-1:0]  timer;
    logic [WT_W-1:0]   wait_cnt;
    logic              tick, tick_pend, pending;
    logic              launch, take_shadow, accept;
    logic              timeout_hit, overrun_hit;
    logic [DATA_W-1:0] shadow, last_frame, sel_frame;

    // Host handshake: a frame transfers on any edge where host_valid & host_ready;
    // host_ready is simply "shadow empty", so payload is ignored while it is low.
    assign host_ready  = ~pending;
    assign accept      = host_valid & ~pending;

    assign tick        = (timer == TMR_W'(REFRESH_CYC - 1));
    assign launch      = (state == IDLE) && (tick || tick_pend);
    assign take_shadow = launch && !pat_en && pending;
    assign timeout_hit = (state == WAIT) && !phy_done && (wait_cnt == WT_W'(PHY_TO - 1));
    assign overrun_hit = tick && tick_pend;
    assign busy        = (state != IDLE);

    // Shadow contents from before this edge; a same-cycle accept waits for the next launch.
    assign sel_frame = pat_en  ? pat_data :
                       pending ? shadow   : last_frame;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = SEND;
            SEND:    state_nxt = WAIT;
            WAIT:    if (phy_done || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer    <= '0;
            wait_cnt <= '0;
        end else begin
            timer <= tick ? '0 : timer + TMR_W'(1);
            if (state == SEND)      wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + WT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_pend   <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (launch)                     tick_pend <= 1'b0;
            else if (tick && state != IDLE) tick_pend <= 1'b1;
            // A new error event outranks a simultaneous clear.
            if (timeout_hit)  timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
            if (overrun_hit)  overrun_err <= 1'b1;
            else if (err_clr) overrun_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending    <= 1'b0;
            shadow     <= '0;
            last_frame <= '0;
            phy_data   <= '0;
            phy_enable <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            phy_enable <= launch;
            if (accept) begin
                shadow  <= host_data;
                pending <= 1'b1;
            end else if (take_shadow) begin
                pending <= 1'b0;
            end
            if (launch) begin
                phy_data  <= sel_frame;
                frame_cnt <= frame_cnt + CNT_W'(1);
                if (!pat_en) last_frame <= sel_frame;
            end
        end
    end
endmodule

// File: tb/tb_led_frame_sched.sv
// Directed bench for led_frame_sched: expected launch frames are queued as
// stimulus is applied and checked against phy_data at each phy_enable strobe.
module tb_led_frame_sched;
    localparam int DATA_W      = 128;
    localparam int REFRESH_CYC = 8;
    localparam int PHY_TO      = 16;
    localparam int CNT_W       = 16;

    logic              clk, rstn;
    logic              host_valid, host_ready;
    logic [DATA_W-1:0] host_data;
    logic              pat_en;
    logic [DATA_W-1:0] pat_data;
    logic              phy_enable, phy_done, busy;
    logic [DATA_W-1:0] phy_data;
    logic [CNT_W-1:0]  frame_cnt;
    logic              timeout_err, overrun_err, err_clr;

    led_frame_sched #(
        .DATA_W(DATA_W), .REFRESH_CYC(REFRESH_CYC), .PHY_TO(PHY_TO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
        .pat_en(pat_en), .pat_data(pat_data),
        .phy_enable(phy_enable), .phy_data(phy_data), .phy_done(phy_done),
        .busy(busy), .frame_cnt(frame_cnt),
        .timeout_err(timeout_err), .overrun_err(overrun_err), .err_clr(err_clr)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int                n_pass  = 0;
    int                n_total = 0;
    int                n_fail  = 0;
    int                cyc     = 0;
    int                done_dly = 3;
    int                done_cnt = 0;
    logic [CNT_W-1:0]  fc_exp  = '0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] frm_a, frm_b, frm_c, frm_d, frm_e;

    // PHY model: pulses phy_done done_dly cycles after a launch (0 = never).
    initial begin
        phy_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            phy_done = 1'b0;
            if (!rstn) begin
                done_cnt = 0;
            end else if (phy_enable) begin
                done_cnt = done_dly;
            end else if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) phy_done = 1'b1;
            end
        end
    end

    task automatic tick_clk();
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic tick_until(input int target);
        while (cyc < target) tick_clk();
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // driver: offer one host frame and hold it until accepted
    task automatic host_push(input logic [DATA_W-1:0] d);
        int n = 0;
        host_valid = 1'b1;
        host_data  = d;
        while (!host_ready && n < 200) begin
            tick_clk();
            n++;
        end
        chk1("host_accept_ready", host_ready, 1'b1);
        tick_clk();
        host_valid = 1'b0;
    endtask

    // scoreboard: wait for a launch, compare against the head of exp_q
    task automatic wait_launch(input int exp_cyc);
        int n = 0;
        logic [DATA_W-1:0] e;
        while (phy_enable !== 1'b1 && n < 200) begin
            tick_clk();
            n++;
        end
        chk1("launch_seen", phy_enable, 1'b1);
        chk("launch_cycle", DATA_W'(cyc), DATA_W'(exp_cyc));
        e = exp_q.pop_front();
        chk("phy_data", phy_data, e);
        fc_exp = fc_exp + CNT_W'(1);
        chk("frame_cnt", DATA_W'(frame_cnt), DATA_W'(fc_exp));
        tick_clk();
        chk1("enable_one_cycle", phy_enable, 1'b0);
        chk1("busy_after_launch", busy, 1'b1);
        chk("phy_data_held", phy_data, e);
    endtask

    initial begin
        rstn = 1'b0; host_valid = 1'b0; host_data = '0; err_clr = 1'b0;
        pat_en = 1'b1; pat_data = {64{2'b01}};
        frm_a = 128'h0123456789abcdef_0123456789abcdef;
        frm_b = 128'hfedcba9876543210_fedcba9876543210;
        frm_c = {$urandom, $urandom, $urandom, $urandom};
        frm_d = {$urandom, $urandom, $urandom, $urandom};
        frm_e = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_phy_enable", phy_enable, 1'b0);
        chk("rst_phy_data", phy_data, '0);
        chk1("rst_host_ready", host_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_frame_cnt", DATA_W'(frame_cnt), '0);
        chk1("rst_timeout", timeout_err, 1'b0);
        chk1("rst_overrun", overrun_err, 1'b0);
        rstn = 1'b1;
        cyc  = 0;

        // test pattern launches on every refresh tick
        repeat (3) exp_q.push_back({64{2'b01}});
        wait_launch(8);
        wait_launch(16);
        wait_launch(24);
        chk("pat_frame_cnt", DATA_W'(frame_cnt), DATA_W'(3));

        // host frame A, then repeated with nothing new queued
        pat_en = 1'b0;
        host_push(frm_a);
        chk1("ready_low_pending", host_ready, 1'b0);
        exp_q.push_back(frm_a);
        wait_launch(32);
        chk1("ready_back_high", host_ready, 1'b1);
        exp_q.push_back(frm_a);
        wait_launch(40);

        // C pending, B held off until C launches
        host_push(frm_c);
        host_valid = 1'b1;
        host_data  = frm_b;
        chk1("b_held_off", host_ready, 1'b0);
        exp_q.push_back(frm_c);
        exp_q.push_back(frm_b);
        wait_launch(48);
        host_valid = 1'b0;
        chk1("b_now_pending", host_ready, 1'b0);
        wait_launch(56);

        // accept in the launch-decision cycle: launch repeats B, D goes next
        tick_until(63);
        host_valid = 1'b1;
        host_data  = frm_d;
        chk1("ready_in_tick_cycle", host_ready, 1'b1);
        exp_q.push_back(frm_b);
        exp_q.push_back(frm_d);
        wait_launch(64);
        host_valid = 1'b0;
        chk1("d_pending", host_ready, 1'b0);
        wait_launch(72);

        // PHY never answers: timeout after 16 WAIT cycles, missed ticks overrun
        done_dly = 0;
        exp_q.push_back(frm_d);
        wait_launch(80);
        tick_until(96);
        chk1("wait_busy", busy, 1'b1);
        chk1("no_timeout_yet", timeout_err, 1'b0);
        chk1("overrun_set", overrun_err, 1'b1);
        tick_clk();
        chk1("timeout_idle", busy, 1'b0);
        chk1("timeout_set", timeout_err, 1'b1);
        done_dly = 3;
        exp_q.push_back(frm_d);
        wait_launch(98);
        chk1("timeout_sticky", timeout_err, 1'b1);
        err_clr = 1'b1;
        tick_clk();
        err_clr = 1'b0;
        chk1("timeout_cleared", timeout_err, 1'b0);
        chk1("overrun_cleared", overrun_err, 1'b0);

        // slow PHY: one missed tick is pended and launched right after IDLE
        done_dly = 12;
        exp_q.push_back(frm_d);
        wait_launch(104);
        done_dly = 3;
        exp_q.push_back(frm_d);
        wait_launch(118);
        chk1("no_overrun_single_miss", overrun_err, 1'b0);
        exp_q.push_back(frm_d);
        wait_launch(123);
        exp_q.push_back(frm_d);
        wait_launch(128);

        // asynchronous reset in WAIT with a frame pending
        host_push(frm_e);
        chk1("e_pending", host_ready, 1'b0);
        rstn = 1'b0;
        #1;
        chk1("mid_rst_enable", phy_enable, 1'b0);
        chk("mid_rst_phy_data", phy_data, '0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_ready", host_ready, 1'b1);
        chk("mid_rst_frame_cnt", DATA_W'(frame_cnt), '0);
        fc_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc  = 0;
        exp_q.push_back('0);
        wait_launch(8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
